// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues loads/stores to data memory over a valid/ready handshake
// and produces registered MEM/WB results. Define MEM_ALIGN_CHECK_EN to fault misaligned accesses.
module mem_access_unit #(
    parameter int CORE         = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_load,
    input  logic                    mem_store,
    input  logic                    mem_regWrite,
    input  logic [DATA_WIDTH-1:0]   mem_ALU_result,
    input  logic [DATA_WIDTH-1:0]   mem_store_data,
    input  logic [4:0]              mem_rd,
    output logic                    dmem_req_valid,
    input  logic                    dmem_req_ready,
    output logic                    dmem_req_we,
    output logic [ADDRESS_BITS-1:0] dmem_req_addr,
    output logic [DATA_WIDTH-1:0]   dmem_req_wdata,
    input  logic                    dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   dmem_resp_rdata,
    output logic                    stall,
    output logic                    wb_valid,
    output logic                    wb_regWrite,
    output logic [4:0]              wb_rd,
    output logic [DATA_WIDTH-1:0]   wb_data,
    output logic                    misaligned_fault
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    state_t                  state_reg;
    logic                    req_valid_reg;
    logic                    we_reg;
    logic [ADDRESS_BITS-1:0] addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [4:0]              rd_reg;
    logic                    regwrite_reg;
    logic                    wb_valid_reg;
    logic                    wb_regwrite_reg;
    logic [4:0]              wb_rd_reg;
    logic [DATA_WIDTH-1:0]   wb_data_reg;

    logic mem_op;
    logic misaligned;
    logic unused_bits;

    assign mem_op      = mem_load | mem_store;
    assign unused_bits = ^{mem_ALU_result, CORE};

`ifdef MEM_ALIGN_CHECK_EN
    logic fault_reg;
    assign misaligned       = mem_op && (mem_ALU_result[1:0] != 2'b00);
    assign misaligned_fault = fault_reg;
`else
    assign misaligned       = 1'b0;
    assign misaligned_fault = 1'b0;
`endif

    assign dmem_req_valid = req_valid_reg;
    assign dmem_req_we    = we_reg;
    assign dmem_req_addr  = addr_reg;
    assign dmem_req_wdata = wdata_reg;
    assign wb_valid       = wb_valid_reg;
    assign wb_regWrite    = wb_regwrite_reg;
    assign wb_rd          = wb_rd_reg;
    assign wb_data        = wb_data_reg;

    // Stall drops in the cycle the open access retires so EX/MEM advances on that edge.
    always_comb begin
        stall = 1'b0;
        case (state_reg)
            IDLE:    stall = mem_op && !misaligned;
            REQ:     stall = !(dmem_req_ready && (we_reg || dmem_resp_valid));
            WAIT:    stall = !dmem_resp_valid;
            default: stall = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            req_valid_reg   <= 1'b0;
            we_reg          <= 1'b0;
            addr_reg        <= '0;
            wdata_reg       <= '0;
            rd_reg          <= 5'd0;
            regwrite_reg    <= 1'b0;
            wb_valid_reg    <= 1'b0;
            wb_regwrite_reg <= 1'b0;
            wb_rd_reg       <= 5'd0;
            wb_data_reg     <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            fault_reg       <= 1'b0;
`endif
        end else begin
            wb_valid_reg <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            fault_reg    <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (misaligned) begin
                        wb_valid_reg    <= 1'b1;
                        wb_regwrite_reg <= 1'b0;
                        wb_rd_reg       <= mem_rd;
                        wb_data_reg     <= mem_ALU_result;
`ifdef MEM_ALIGN_CHECK_EN
                        fault_reg       <= 1'b1;
`endif
                    end else if (mem_op) begin
                        // A load with the store bit also set is issued as a load.
                        we_reg        <= mem_store && !mem_load;
                        addr_reg      <= mem_ALU_result[ADDRESS_BITS+1:2];
                        wdata_reg     <= mem_store_data;
                        rd_reg        <= mem_rd;
                        regwrite_reg  <= mem_regWrite;
                        req_valid_reg <= 1'b1;
                        state_reg     <= REQ;
                    end else begin
                        wb_valid_reg    <= 1'b1;
                        wb_regwrite_reg <= mem_regWrite && (mem_rd != 5'd0);
                        wb_rd_reg       <= mem_rd;
                        wb_data_reg     <= mem_ALU_result;
                    end
                end
                REQ: begin
                    if (dmem_req_ready) begin
                        req_valid_reg <= 1'b0;
                        if (we_reg) begin
                            wb_valid_reg    <= 1'b1;
                            wb_regwrite_reg <= 1'b0;
                            wb_rd_reg       <= rd_reg;
                            state_reg       <= IDLE;
                        end else if (dmem_resp_valid) begin
                            wb_valid_reg    <= 1'b1;
                            wb_regwrite_reg <= regwrite_reg && (rd_reg != 5'd0);
                            wb_rd_reg       <= rd_reg;
                            wb_data_reg     <= dmem_resp_rdata;
                            state_reg       <= IDLE;
                        end else begin
                            state_reg <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_resp_valid) begin
                        wb_valid_reg    <= 1'b1;
                        wb_regwrite_reg <= regwrite_reg && (rd_reg != 5'd0);
                        wb_rd_reg       <= rd_reg;
                        wb_data_reg     <= dmem_resp_rdata;
                        state_reg       <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: the bench plays pipeline and data memory and
// predicts stall length, request fields and write-back for every op from its arithmetic rules.
module tb_mem_access_unit;

    logic        clock;
    logic        reset;
    logic        mem_load;
    logic        mem_store;
    logic        mem_regWrite;
    logic [31:0] mem_ALU_result;
    logic [31:0] mem_store_data;
    logic [4:0]  mem_rd;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [19:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        stall;
    logic        wb_valid;
    logic        wb_regWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misaligned_fault;

    int compared;
    int mismatched;
    int op_count;

    // Expected write-back of the most recently retired op, seen one cycle later.
    bit          pend;
    bit          p_rw;
    bit [4:0]    p_rd;
    bit [31:0]   p_data;
    bit          p_chk_rd;
    bit          p_chk_data;
    bit          p_fault;
    bit [31:0]   last_data;
    bit          last_known;

    mem_access_unit #(
        .CORE(0),
        .DATA_WIDTH(32),
        .ADDRESS_BITS(20)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem_load(mem_load),
        .mem_store(mem_store),
        .mem_regWrite(mem_regWrite),
        .mem_ALU_result(mem_ALU_result),
        .mem_store_data(mem_store_data),
        .mem_rd(mem_rd),
        .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready),
        .dmem_req_we(dmem_req_we),
        .dmem_req_addr(dmem_req_addr),
        .dmem_req_wdata(dmem_req_wdata),
        .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_rdata(dmem_resp_rdata),
        .stall(stall),
        .wb_valid(wb_valid),
        .wb_regWrite(wb_regWrite),
        .wb_rd(wb_rd),
        .wb_data(wb_data),
        .misaligned_fault(misaligned_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic check_pending();
        if (pend) begin
            check("wb_valid", wb_valid, 1'b1);
            check("wb_regWrite", wb_regWrite, p_rw);
            if (p_chk_rd)   check("wb_rd", wb_rd, p_rd);
            if (p_chk_data) check("wb_data", wb_data, p_data);
            check("misaligned_fault", misaligned_fault, p_fault);
            pend = 1'b0;
        end else begin
            check("wb_valid_quiet", wb_valid, 1'b0);
        end
    endtask

    task automatic zero_inputs();
        mem_load        = 1'b0;
        mem_store       = 1'b0;
        mem_regWrite    = 1'b0;
        mem_ALU_result  = 32'h0;
        mem_store_data  = 32'h0;
        mem_rd          = 5'd0;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_rdata = 32'h0;
    endtask

    // Called mid-cycle; the first edge after release retires an all-zero non-memory op.
    task automatic release_reset();
        zero_inputs();
        reset      = 1'b0;
        pend       = 1'b1;
        p_rw       = 1'b0;
        p_rd       = 5'd0;
        p_data     = 32'h0;
        p_chk_rd   = 1'b1;
        p_chk_data = 1'b1;
        p_fault    = 1'b0;
        last_data  = 32'h0;
        last_known = 1'b1;
        @(posedge clock);
        #1;
    endtask

    // Presents one op (held while stalled) and acts as memory: ready after rdy request
    // cycles, load data resp cycles after acceptance (0 = same cycle).
    task automatic run_op(input logic ld, input logic st, input logic rw, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] sdata, input logic [31:0] rdata,
                          input int rdy, input int resp, input bit junk);
        bit is_mem, is_load, is_store, misal, done, accepted;
        int cyc, nstall, req_seen, acc_cyc, exp_stall;
        is_mem   = ld || st;
        is_load  = ld;
        is_store = st && !ld;
        misal    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misal    = is_mem && (alu[1:0] != 2'b00);
`endif
        exp_stall = (!is_mem || misal) ? 0 : (is_load ? 1 + rdy + resp : 1 + rdy);
        mem_load       = ld;
        mem_store      = st;
        mem_regWrite   = rw;
        mem_rd         = rd;
        mem_ALU_result = alu;
        mem_store_data = sdata;
        cyc = 0; nstall = 0; req_seen = 0; acc_cyc = 0; accepted = 1'b0; done = 1'b0;
        while (!done && cyc < 64) begin
            dmem_req_ready  = 1'b0;
            dmem_resp_valid = 1'b0;
            dmem_resp_rdata = $urandom;
            if (dmem_req_valid && !accepted) begin
                dmem_req_ready = (req_seen == rdy);
                if (dmem_req_ready && is_load && resp == 0) begin
                    dmem_resp_valid = 1'b1;
                    dmem_resp_rdata = rdata;
                end else if (!dmem_req_ready && junk) begin
                    dmem_resp_valid = 1'b1;
                end
            end else if (accepted && is_load && cyc == acc_cyc + resp) begin
                dmem_resp_valid = 1'b1;
                dmem_resp_rdata = rdata;
            end else if (junk && cyc == 0) begin
                dmem_resp_valid = 1'b1;
            end
            @(negedge clock);
            if (cyc == 0) begin
                check_pending();
                check("req_valid_idle", dmem_req_valid, 1'b0);
            end else begin
                check("wb_valid_busy", wb_valid, 1'b0);
                if (last_known) check("wb_data_hold", wb_data, last_data);
            end
            if (dmem_req_valid) begin
                check("req_addr", dmem_req_addr, alu[21:2]);
                check("req_we", dmem_req_we, is_store);
                if (is_store) check("req_wdata", dmem_req_wdata, sdata);
                if (dmem_req_ready) begin
                    accepted = 1'b1;
                    acc_cyc  = cyc;
                end
                req_seen++;
            end
            if (stall) nstall++;
            else       done = 1'b1;
            @(posedge clock);
            #1;
            cyc++;
        end
        check("op_done", done, 1'b1);
        check("stall_cycles", nstall, exp_stall);
        check("req_issued", accepted, is_mem && !misal);
        pend       = 1'b1;
        p_rw       = (is_store || misal) ? 1'b0 : (rw && (rd != 5'd0));
        p_rd       = rd;
        p_chk_rd   = !is_store && !misal;
        p_data     = is_load ? rdata : alu;
        p_chk_data = !is_store && !misal;
        p_fault    = misal;
        last_known = !is_store && !misal;
        last_data  = p_data;
        $display("op %0d: ld=%0b st=%0b rd=%0d addr=%h rdy=%0d resp=%0d stall=%0d",
                 op_count, ld, st, rd, alu, rdy, resp, nstall);
        op_count++;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        op_count   = 0;
        pend       = 1'b0;
        last_known = 1'b0;
        reset      = 1'b1;
        zero_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_req_valid", dmem_req_valid, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_regWrite", wb_regWrite, 1'b0);
        check("rst_wb_rd", wb_rd, 5'd0);
        check("rst_wb_data", wb_data, 32'h0);
        check("rst_fault", misaligned_fault, 1'b0);
        release_reset();

        // Non-memory op, load with multi-cycle response, store with back-pressure, load to x0.
        run_op(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, 32'h0, 0, 0, 1'b0);
        run_op(1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 0, 3, 1'b0);
        run_op(1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0080, 32'hA5A5_A5A5, 32'h0, 3, 0, 1'b1);
        run_op(1'b1, 1'b0, 1'b1, 5'd0, 32'h0000_0044, 32'h0, 32'h1357_9BDF, 1, 1, 1'b1);
        run_op(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0048, 32'h0, 32'hCAFE_F00D, 0, 0, 1'b0);
        run_op(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_004C, 32'h1111_1111, 32'h2468_ACE0, 2, 0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
        run_op(1'b1, 1'b0, 1'b1, 5'd6, 32'h0000_0042, 32'h0, 32'h0, 0, 0, 1'b0);
`endif

        // Reset while a load waits for its response drops the access.
        mem_load        = 1'b1;
        mem_store       = 1'b0;
        mem_regWrite    = 1'b1;
        mem_rd          = 5'd9;
        mem_ALU_result  = 32'h0000_0100;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        @(negedge clock);
        check_pending();
        check("rstw_idle_stall", stall, 1'b1);
        @(posedge clock);
        #1 dmem_req_ready = 1'b1;
        @(negedge clock);
        check("rstw_req_valid", dmem_req_valid, 1'b1);
        @(posedge clock);
        #1 dmem_req_ready = 1'b0;
        @(negedge clock);
        check("rstw_wait_stall", stall, 1'b1);
        check("rstw_wait_req", dmem_req_valid, 1'b0);
        #1 reset = 1'b1;
        #1 zero_inputs();
        #1;
        check("rstw_mid_req_valid", dmem_req_valid, 1'b0);
        check("rstw_mid_stall", stall, 1'b0);
        check("rstw_mid_wb_valid", wb_valid, 1'b0);
        @(posedge clock);
        #1;
        dmem_resp_valid = 1'b1;
        dmem_resp_rdata = 32'hBAD0_BAD0;
        @(negedge clock);
        check("rstw_stale_resp", wb_valid, 1'b0);
        release_reset();

        for (int i = 0; i < 200; i++) begin
            int   k;
            logic ld;
            logic st;
            k  = int'($urandom_range(0, 3));
            ld = (k == 1) || (k == 3);
            st = (k == 2) || (k == 3);
            run_op(ld, st, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)));
        end

        zero_inputs();
        @(negedge clock);
        check_pending();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
